a2d_intf: RTL and testbench
===========================

Name: a2d_intf

Overview:
- Upstream feeder for the steering-enable logic and the balance/steer path.
- Round-robins 12-bit conversions from an external SPI ADC over four channels: left load cell, right load cell, steering pot, battery.
- Holds each result in an output register. lft_ld/rght_ld feed the steering-enable block directly.
- One conversion per `nxt` request; the channel pointer advances after each completed conversion.

Parameters:
- SCLK_DIV_W, 5: width of the SCLK divider counter; SCLK period = 2^SCLK_DIV_W clk cycles (32).
- CH_LFT, 3'd0: ADC channel for left load cell.
- CH_RGHT, 3'd4: ADC channel for right load cell.
- CH_STEER, 3'd5: ADC channel for steering pot.
- CH_BATT, 3'd6: ADC channel for battery.

Ports:
- clk  input  1  system clock
- rst_n  input  1  asynchronous active-low reset
- nxt  input  1  single-cycle request to start the next conversion; ignored while busy
- MISO  input  1  serial data from ADC
- SS_n  output  1  ADC slave select, active low
- SCLK  output  1  serial clock
- MOSI  output  1  serial data to ADC
- lft_ld  output  12  latest left load cell reading
- rght_ld  output  12  latest right load cell reading
- steer_pot  output  12  latest steering pot reading
- batt  output  12  latest battery reading
- cnv_cmplt  output  1  one-cycle pulse when a result register updates

Behaviour:
- Reset (async, rst_n low): all four result registers 12'h000, cnv_cmplt 0, SS_n 1, SCLK 1, MOSI 0, channel pointer 0 (lft), FSM IDLE.
- Transaction format: 16-bit SPI frame, MSB first, SPI mode 3.
  - SCLK idles high; MOSI changes on SCLK fall; MISO is sampled on SCLK rise.
- SPI sub-module sequence:
  - `wrt` drops SS_n.
  - 32-clk front porch follows, with SCLK high.
  - 16 SCLK periods follow.
  - SS_n returns high 16 clks after the last rising edge.
  - `done` pulses for one cycle as SS_n rises.
- Conversion = two back-to-back frames:
  - Frame 1 (command): MOSI = {2'b00, chnl[2:0], 11'h000}; received data is discarded.
  - Frame 2 (read): MOSI = 16'h0000; result = rx[11:0].
- FSM states:
  - IDLE: on nxt, start frame 1 (cmd) → CMD.
  - CMD: on done → GAP.
  - GAP: exactly one clk, SS_n held high → start frame 2 → READ.
  - READ: on done, write result into the register selected by the pointer, pulse cnv_cmplt for one cycle, advance the pointer → IDLE.
- Pointer order: lft → rght → steer → batt → lft (wraps after batt).
- Latency from nxt to cnv_cmplt: fixed. The SPI sub-module defines it; the bench measures it once and checks it is identical on every conversion.
- Register update rules:
  - Only the addressed register updates; the other three hold.
  - The update occurs on the same edge that cnv_cmplt asserts.
- nxt while not IDLE: ignored, not queued.
- nxt coincident with a READ-done cycle: ignored (FSM still in READ that cycle).
- rst_n asserted mid-frame:
  - Immediate abort: SS_n 1, SCLK 1, pointer back to lft, registers cleared.
  - No cnv_cmplt pulse.
- MISO is treated as synchronous to the ADC model; no metastability flops required.

Optional Feature:
- A2D_AVG_EN
- Defined:
  - lft_ld and rght_ld present the 2-sample running average: out = ({1'b0, prev_sample} + {1'b0, new_sample}) >> 1, computed in 13 bits and truncated.
  - prev_sample is reset to 0.
  - steer_pot and batt are unaffected.
- Undefined: every output is the raw latest sample.

Decomposition:
- Shared package a2d_pkg:
  - channel localparams (CH_LFT..CH_BATT);
  - pointer enum (PTR_LFT, PTR_RGHT, PTR_STEER, PTR_BATT);
  - FSM state enum (IDLE, CMD, GAP, READ);
  - frame width 16.
- One sub-module: spi_mnrch.
  - Generic 16-bit SPI master.
  - Ports: wrt, cmd[15:0], done, rd_data[15:0], SS_n, SCLK, MOSI, MISO.
  - Contains its own divider, bit counter, shift register and FSM.
- a2d_intf contains the sequencing FSM, pointer and result registers.

Test Plan:
- Reset: hold rst_n low 3 clks → SS_n=1, SCLK=1, all outputs 12'h000, cnv_cmplt=0.
- Left conversion (ADC model returns 12'h3A5 for ch0): pulse nxt →
  - frame 1 MOSI = 16'h0000;
  - frame 2 returns 3A5;
  - lft_ld=12'h3A5, others remain 0, one cnv_cmplt pulse.
- Round robin (model returns ch0=12'h111, ch4=12'h222, ch5=12'h333, ch6=12'h444): four nxt pulses →
  - command frames carry 16'h0000, 16'h2000, 16'h2800, 16'h3000;
  - registers = 111/222/333/444;
  - fifth nxt re-targets ch0.
- nxt re-pulsed mid-frame and at the READ-done cycle → no extra transaction; frame count stays 2 per accepted nxt.
- rst_n dropped during frame 2 of rght conversion →
  - SS_n=1 immediately, rght_ld=0, no cnv_cmplt;
  - next nxt targets ch0.
- A2D_AVG_EN defined: left samples 12'h100 then 12'h301 → lft_ld 12'h080 then 12'h200; steer_pot raw.

Source files
------------

// File: rtl/a2d_pkg.sv
// Shared types and constants for the a2d_intf ADC round-robin sequencer
// and its SPI master.
package a2d_pkg;

  localparam int unsigned FRAME_W = 16;
  localparam int unsigned RES_W   = 12;

  localparam logic [2:0] CH_LFT   = 3'd0;
  localparam logic [2:0] CH_RGHT  = 3'd4;
  localparam logic [2:0] CH_STEER = 3'd5;
  localparam logic [2:0] CH_BATT  = 3'd6;

  typedef enum logic [1:0] {
    PTR_LFT,
    PTR_RGHT,
    PTR_STEER,
    PTR_BATT
  } ptr_t;

  typedef enum logic [1:0] {
    IDLE,
    CMD,
    GAP,
    READ
  } a2d_state_t;

  typedef enum logic [1:0] {
    SPI_IDLE,
    SPI_PORCH,
    SPI_SHIFT
  } spi_state_t;

  function automatic logic [2:0] ptr_to_chnl(input ptr_t p);
    logic [2:0] ch;
    case (p)
      PTR_LFT:   ch = CH_LFT;
      PTR_RGHT:  ch = CH_RGHT;
      PTR_STEER: ch = CH_STEER;
      default:   ch = CH_BATT;
    endcase
    return ch;
  endfunction

  function automatic logic [FRAME_W-1:0] cmd_frame(input logic [2:0] ch);
    return {2'b00, ch, 11'h000};
  endfunction

  // Two-sample mean, summed in 13 bits so the carry is kept before the shift.
  function automatic logic [RES_W-1:0] avg2(input logic [RES_W-1:0] a,
                                            input logic [RES_W-1:0] b);
    logic [RES_W:0] sum;
    sum = {1'b0, a} + {1'b0, b};
    return sum[RES_W:1];
  endfunction

endpackage

// File: rtl/spi_mnrch.sv
// Generic 16-bit SPI master, mode 3 (SCLK idles high, MOSI changes on fall,
// MISO sampled on rise), with a full SCLK period of front porch.
module spi_mnrch
  import a2d_pkg::*;
#(
  parameter int unsigned SCLK_DIV_W = 5
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               wrt,
  input  logic [FRAME_W-1:0] cmd,
  output logic               done,
  output logic [FRAME_W-1:0] rd_data,
  output logic               SS_n,
  output logic               SCLK,
  output logic               MOSI,
  input  logic               MISO
);

  localparam logic [SCLK_DIV_W-1:0] DIV_LAST = '1;
  localparam logic [SCLK_DIV_W-1:0] DIV_HALF = DIV_LAST >> 1;
  localparam logic [3:0]            BIT_LAST = 4'(FRAME_W - 1);

  spi_state_t              state_q, state_d;
  logic [SCLK_DIV_W-1:0]   div;
  logic [3:0]              bit_cnt;
  logic [FRAME_W-1:0]      shft;
  logic                    miso_smpl;
  logic                    div_end;
  logic                    last_bit;

  assign div_end  = (div == DIV_LAST);
  assign last_bit = (bit_cnt == BIT_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= SPI_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      SPI_IDLE:  if (wrt) state_d = SPI_PORCH;
      SPI_PORCH: if (div_end) state_d = SPI_SHIFT;
      SPI_SHIFT: if (div_end && last_bit) state_d = SPI_IDLE;
      default:   state_d = SPI_IDLE;
    endcase
  end

  // Each bit period is SCLK low for the first half of the divider and high for
  // the second; the sampled MISO bit is shifted in at the following fall so the
  // shared shift register only moves MOSI on falling edges.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div       <= '0;
      bit_cnt   <= '0;
      shft      <= '0;
      miso_smpl <= 1'b0;
      SS_n      <= 1'b1;
      SCLK      <= 1'b1;
      done      <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state_q)
        SPI_IDLE: begin
          if (wrt) begin
            SS_n    <= 1'b0;
            shft    <= cmd;
            div     <= '0;
            bit_cnt <= '0;
          end
        end
        SPI_PORCH: begin
          div <= div + 1'b1;
          if (div_end) SCLK <= 1'b0;
        end
        SPI_SHIFT: begin
          div <= div + 1'b1;
          if (div == DIV_HALF) begin
            SCLK      <= 1'b1;
            miso_smpl <= MISO;
          end
          if (div_end) begin
            shft    <= {shft[FRAME_W-2:0], miso_smpl};
            bit_cnt <= bit_cnt + 1'b1;
            if (last_bit) begin
              SS_n <= 1'b1;
              done <= 1'b1;
            end else begin
              SCLK <= 1'b0;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign MOSI    = SS_n ? 1'b0 : shft[FRAME_W-1];
  assign rd_data = shft;

endmodule

// File: rtl/a2d_intf.sv
// Round-robin ADC sequencer: one two-frame conversion per nxt over lft/rght/
// steer/batt. Define A2D_AVG_EN to average the last two load-cell samples.
module a2d_intf
  import a2d_pkg::*;
#(
  parameter int unsigned SCLK_DIV_W = 5
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        nxt,
  input  logic        MISO,
  output logic        SS_n,
  output logic        SCLK,
  output logic        MOSI,
  output logic [11:0] lft_ld,
  output logic [11:0] rght_ld,
  output logic [11:0] steer_pot,
  output logic [11:0] batt,
  output logic        cnv_cmplt
);

  a2d_state_t         state_q, state_d;
  ptr_t               ptr;
  logic               wrt;
  logic [FRAME_W-1:0] cmd;
  logic               done;
  logic [FRAME_W-1:0] rd_data;
  logic [RES_W-1:0]   sample;
  logic               wr_en;
  logic               unused_rd;

  spi_mnrch #(
    .SCLK_DIV_W(SCLK_DIV_W)
  ) u_spi (
    .clk    (clk),
    .rst_n  (rst_n),
    .wrt    (wrt),
    .cmd    (cmd),
    .done   (done),
    .rd_data(rd_data),
    .SS_n   (SS_n),
    .SCLK   (SCLK),
    .MOSI   (MOSI),
    .MISO   (MISO)
  );

  assign sample    = rd_data[RES_W-1:0];
  assign unused_rd = ^rd_data[FRAME_W-1:RES_W];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    wrt     = 1'b0;
    cmd     = '0;
    case (state_q)
      IDLE: begin
        if (nxt) begin
          wrt     = 1'b1;
          cmd     = cmd_frame(ptr_to_chnl(ptr));
          state_d = CMD;
        end
      end
      CMD:  if (done) state_d = GAP;
      GAP: begin
        wrt     = 1'b1;
        state_d = READ;
      end
      READ: if (done) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign wr_en = (state_q == READ) && done;

`ifdef A2D_AVG_EN
  logic [RES_W-1:0] lft_prev, rght_prev;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lft_ld    <= '0;
      rght_ld   <= '0;
      steer_pot <= '0;
      batt      <= '0;
      cnv_cmplt <= 1'b0;
      ptr       <= PTR_LFT;
`ifdef A2D_AVG_EN
      lft_prev  <= '0;
      rght_prev <= '0;
`endif
    end else begin
      cnv_cmplt <= wr_en;
      if (wr_en) begin
        case (ptr)
`ifdef A2D_AVG_EN
          PTR_LFT: begin
            lft_ld   <= avg2(lft_prev, sample);
            lft_prev <= sample;
          end
          PTR_RGHT: begin
            rght_ld   <= avg2(rght_prev, sample);
            rght_prev <= sample;
          end
`else
          PTR_LFT:   lft_ld  <= sample;
          PTR_RGHT:  rght_ld <= sample;
`endif
          PTR_STEER: steer_pot <= sample;
          default:   batt      <= sample;
        endcase
        ptr <= ptr_t'(ptr + 2'd1);
      end
    end
  end

endmodule

// File: tb/tb_a2d_intf.sv
// Self-checking bench for a2d_intf: behavioural SPI ADC plus a reference
// model of the round-robin pointer and result registers.
module tb_a2d_intf;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        nxt = 1'b0;
  logic        MISO = 1'b0;
  logic        SS_n, SCLK, MOSI, cnv_cmplt;
  logic [11:0] lft_ld, rght_ld, steer_pot, batt;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  a2d_intf #(.SCLK_DIV_W(5)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .nxt      (nxt),
    .MISO     (MISO),
    .SS_n     (SS_n),
    .SCLK     (SCLK),
    .MOSI     (MOSI),
    .lft_ld   (lft_ld),
    .rght_ld  (rght_ld),
    .steer_pot(steer_pot),
    .batt     (batt),
    .cnv_cmplt(cnv_cmplt)
  );

  // ADC model: a command frame selects the channel returned by the next frame.
  logic [11:0] adc_val [8];
  logic [15:0] tx_word = '0;
  logic [15:0] rx_word = '0;
  logic [2:0]  cur_ch = '0;
  logic [3:0]  bidx;
  bit          next_is_cmd = 1'b1;
  int          rises = 0;
  int          ss_falls = 0;
  int          cmplt_pulses = 0;
  logic [15:0] frames [$];
  int          frame_rises [$];

  always @(negedge SS_n) if (rst_n) begin
    ss_falls++;
    rises   = 0;
    rx_word = '0;
    tx_word = next_is_cmd ? 16'($urandom) : {4'($urandom), adc_val[cur_ch]};
    MISO    = tx_word[15];
  end

  always @(posedge SCLK) if (rst_n && SS_n === 1'b0) begin
    rx_word = {rx_word[14:0], MOSI};
    rises++;
  end

  always @(negedge SCLK) if (rst_n && SS_n === 1'b0 && rises < 16) begin
    bidx = 4'(15 - rises);
    MISO = tx_word[bidx];
  end

  always @(posedge SS_n) if (rst_n) begin
    frames.push_back(rx_word);
    frame_rises.push_back(rises);
    if (next_is_cmd) cur_ch = rx_word[13:11];
    next_is_cmd = !next_is_cmd;
  end

  always @(negedge clk) if (cnv_cmplt === 1'b1) cmplt_pulses++;

  // Reference model
  logic [1:0]  ptr_m = 2'd0;
  logic [11:0] exp_reg [4];
  logic [11:0] prev_m [2];
  int          lat_ref = -1;

  function automatic logic [2:0] ch_of(input logic [1:0] p);
    case (p)
      2'd0:    return 3'd0;
      2'd1:    return 3'd4;
      2'd2:    return 3'd5;
      default: return 3'd6;
    endcase
  endfunction

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_regs(input string tag);
    check({tag, "_lft"},   {4'h0, lft_ld},    {4'h0, exp_reg[0]});
    check({tag, "_rght"},  {4'h0, rght_ld},   {4'h0, exp_reg[1]});
    check({tag, "_steer"}, {4'h0, steer_pot}, {4'h0, exp_reg[2]});
    check({tag, "_batt"},  {4'h0, batt},      {4'h0, exp_reg[3]});
  endtask

  task automatic randomize_adc();
    for (int i = 0; i < 8; i++) adc_val[i] = 12'($urandom);
  endtask

  task automatic apply_reset();
    #1 rst_n = 1'b0;
    #1;
    check("rst_ss_n",  {15'h0, SS_n},      16'h0001);
    check("rst_sclk",  {15'h0, SCLK},      16'h0001);
    check("rst_mosi",  {15'h0, MOSI},      16'h0000);
    check("rst_cmplt", {15'h0, cnv_cmplt}, 16'h0000);
    ptr_m       = 2'd0;
    next_is_cmd = 1'b1;
    for (int i = 0; i < 4; i++) exp_reg[i] = '0;
    prev_m[0] = '0;
    prev_m[1] = '0;
    check_regs("rst");
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic do_conv(input bit repulse);
    int          cyc;
    int          f0;
    int          sf0;
    int          p0;
    logic [2:0]  ch;
    logic [11:0] s;
    ch  = ch_of(ptr_m);
    f0  = frames.size();
    sf0 = ss_falls;
    p0  = cmplt_pulses;
    @(negedge clk);
    nxt = 1'b1;
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
      nxt = repulse && (cyc == 200 || cyc == 700 || (lat_ref > 0 && cyc == lat_ref - 1));
    end while (cnv_cmplt !== 1'b1 && cyc < 3000);
    nxt = 1'b0;
    check("cmplt_seen", {15'h0, cnv_cmplt}, 16'h0001);
    if (lat_ref < 0) lat_ref = cyc;
    else check("latency", 16'(cyc), 16'(lat_ref));

    s = adc_val[ch];
`ifdef A2D_AVG_EN
    if (ptr_m < 2'd2) begin
      exp_reg[ptr_m] = 12'((int'(prev_m[ptr_m[0]]) + int'(s)) / 2);
      prev_m[ptr_m[0]] = s;
    end else begin
      exp_reg[ptr_m] = s;
    end
`else
    exp_reg[ptr_m] = s;
`endif
    ptr_m = ptr_m + 2'd1;

    check("frames_per_conv", 16'(frames.size() - f0), 16'd2);
    if (frames.size() >= f0 + 2) begin
      check("cmd_frame",  frames[f0],     {2'b00, ch, 11'h000});
      check("read_frame", frames[f0 + 1], 16'h0000);
      check("sclk_rises", 16'(frame_rises[f0 + 1]), 16'd16);
    end
    check_regs("conv");
    @(negedge clk);
    check("cmplt_one_cycle", {15'h0, cnv_cmplt}, 16'h0000);
    repeat (40) @(negedge clk);
    check("ss_falls_per_conv", 16'(ss_falls - sf0), 16'd2);
    check("cmplt_pulses", 16'(cmplt_pulses - p0), 16'd1);
    check("ss_idle",   {15'h0, SS_n}, 16'h0001);
    check("sclk_idle", {15'h0, SCLK}, 16'h0001);
  endtask

  initial begin
    int cyc;
    int sf0;
    int p0;

    randomize_adc();
    apply_reset();

    // Single left conversion
    adc_val[0] = 12'h3A5;
    do_conv(1'b0);

    // Round robin from a clean pointer, with ignored mid-frame / READ-done nxt
    apply_reset();
    randomize_adc();
    adc_val[0] = 12'h111;
    adc_val[4] = 12'h222;
    adc_val[5] = 12'h333;
    adc_val[6] = 12'h444;
    do_conv(1'b0);
    do_conv(1'b1);
    do_conv(1'b0);
    do_conv(1'b1);
    randomize_adc();
    do_conv(1'b1);

    // Abort the rght conversion during its read frame
    sf0 = ss_falls;
    p0  = cmplt_pulses;
    @(negedge clk);
    nxt = 1'b1;
    @(negedge clk);
    nxt = 1'b0;
    cyc = 0;
    while (ss_falls - sf0 < 2 && cyc < 3000) begin
      @(negedge clk);
      cyc++;
    end
    check("abort_frame2_started", 16'(ss_falls - sf0), 16'd2);
    repeat (100) @(negedge clk);
    apply_reset();
    sf0 = ss_falls;
    repeat (lat_ref + 50) @(negedge clk);
    check("abort_no_cmplt", 16'(cmplt_pulses - p0), 16'd0);
    check("abort_no_frame", 16'(ss_falls - sf0), 16'd0);
    check_regs("abort_hold");
    randomize_adc();
    do_conv(1'b0);

    // Randomized conversions
    for (int n = 0; n < 6; n++) begin
      randomize_adc();
      do_conv(1'($urandom));
    end

`ifdef A2D_AVG_EN
    apply_reset();
    randomize_adc();
    adc_val[0] = 12'h100;
    do_conv(1'b0);
    check("avg_lft_first", {4'h0, lft_ld}, 16'h0080);
    do_conv(1'b0);
    adc_val[5] = 12'h5A7;
    do_conv(1'b0);
    check("avg_steer_raw", {4'h0, steer_pot}, 16'h05A7);
    do_conv(1'b0);
    adc_val[0] = 12'h301;
    do_conv(1'b0);
    check("avg_lft_second", {4'h0, lft_ld}, 16'h0200);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
